histogram_sequencer: RTL and testbench
======================================

# histogram_sequencer

Frame-level controller for the pixel histogram block. On each frame request it clears the histogram, streams one frame of binary pixels into it, stops accumulation, and reads back both projections. During readback it tracks the peak bin of the x and y projections. The peak column/row and counts feed the downstream median-filter/localisation logic.

## Interface
Parameters:
- IMWIDTH, 240, number of x bins (columns); must match histogram block
- IMHEIGHT, 180, number of y bins (rows); must match histogram block
- TIMEOUT, 1023, max cycles spent in any wait state before error

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- frameStart  in  1  request one frame cycle; honoured only in IDLE
- pixelValid  in  1  pixelIn/pixelX/pixelY valid this cycle
- pixelIn  in  1  binary pixel value
- pixelX  in  8  column of pixel, 0..IMWIDTH-1
- pixelY  in  8  row of pixel, 0..IMHEIGHT-1
- histXAddress  out  8  registered x address to histogram
- histYAddress  out  8  registered y address to histogram
- histPixelData  out  1  registered pixelIn & pixelValid; 0 outside STREAM
- clearHistogram / startHistogram / stopHistogram / readHistogram  out  1 each  one-cycle command pulses
- histReady  in  1  histogram idle indicator
- xHistogramOut, yHistogramOut  in  8 each  readback bin values
- xValid, yValid  in  1 each  readback bin strobes
- busy  out  1  high in every state except IDLE
- frameDone  out  1  one-cycle pulse, results valid
- peakX, peakY  out  8 each  index of maximum x / y bin
- peakXCount, peakYCount  out  8 each  value of that bin
- error  out  1  sticky timeout flag, cleared by next accepted frameStart

## Operation
- States: IDLE, CLEAR, WAIT_CLEAR, START, STREAM, DRAIN, STOP, READ, WAIT_READ, DONE.
- IDLE: on frameStart, go CLEAR, clear error, peak registers and counters.
- CLEAR: pulse clearHistogram for one cycle, then go WAIT_CLEAR.
- WAIT_CLEAR: wait for histReady to go low, then wait for it to return high. Then go START.
- START: pulse startHistogram, then go STREAM.
- STREAM: each cycle, register pixelX, pixelY and pixelIn&pixelValid onto the hist outputs.
  - 16-bit pixelCount increments on each pixelValid.
  - When the valid with pixelCount == IMWIDTH*IMHEIGHT-1 is accepted, go DRAIN.
- DRAIN: one cycle with histPixelData = 0, so the final registered pixel is written. Then go STOP.
- STOP: pulse stopHistogram. histPixelData stays 0 from here on. Go READ.
- READ: pulse readHistogram, reset xIndex/yIndex to 0, then go WAIT_READ.
- WAIT_READ: on each xValid, compare xHistogramOut against peakXCount.
  - If strictly greater, load peakXCount and set peakX = xIndex.
  - xIndex increments on every xValid. The y projection is handled identically.
  - Exit when histReady falls and then rises again. Go DONE.
- DONE: pulse frameDone for one cycle, then go IDLE. Peak outputs hold until the next frameStart.
- Ties keep the lowest index. An all-zero projection gives peak index 0, count 0.
- xIndex saturates at IMWIDTH-1 and yIndex at IMHEIGHT-1. Extra strobes compare against that index.
- Timeout: a 10-bit wait counter runs in WAIT_CLEAR and WAIT_READ. On reaching TIMEOUT, set error, pulse no command, and go IDLE without a frameDone pulse.
- frameStart outside IDLE is ignored. pixelValid outside STREAM is ignored.
- Reset mid-operation returns to IDLE immediately. No command pulse is emitted on reset release.

## Timing
- Reset values: every output 0, state IDLE, all counters 0.
- Address/data path latency: exactly 1 cycle from pixel inputs to hist outputs.
- Command pulses are registered and last exactly 1 cycle. Only one command is asserted in any cycle.
- frameStart at cycle t gives clearHistogram high at t+1.
- Last valid pixel at cycle t gives stopHistogram at t+2 and readHistogram at t+3.
- frameDone asserts 2 cycles after the cycle where histReady is sampled re-asserted in WAIT_READ.
- Peak registers update 1 cycle after the strobe cycle and are final when frameDone is high.
- busy rises the cycle after frameStart is accepted and falls the cycle after DONE.

## Test plan
- Use IMWIDTH=4, IMHEIGHT=3 with a behavioural histogram model for all scenarios below.
- Normal frame: send 12 valid pixels, with pixelIn=1 at (2,1), (2,0) and (1,1).
  - Expect peakX=2, peakXCount=2, peakY=1, peakYCount=2 and exactly one frameDone.
- Gapped stream: toggle pixelValid randomly.
  - Expect stopHistogram exactly 2 cycles after the 12th valid, with histPixelData=0 in that window.
- Tie and zero frame:
  - Bins x = {3,3,0,1} give peakX=0.
  - An all-zero frame gives all peaks 0.
- Timeout: model holds histReady high after clearHistogram.
  - Expect error=1 after 1023 wait cycles, IDLE, and no frameDone.
  - The next frameStart clears error.
- Reset during STREAM: deassert reset for 1 cycle.
  - Expect all outputs 0 and no command pulses until a new frameStart.
- frameStart while busy: assert it during WAIT_READ.
  - Expect it ignored and a single frameDone.

Source files
------------

// File: rtl/histogram_sequencer_if.sv
// histogram_sequencer_if
// Bundles the connection between the frame sequencer and the pixel histogram
// block.
//   master (sequencer side): drives histXAddress/histYAddress/histPixelData and
//     the one-cycle commands clearHistogram/startHistogram/stopHistogram/
//     readHistogram; receives histReady and the readback bins
//     xHistogramOut/yHistogramOut with their strobes xValid/yValid.
//   slave (histogram side): the mirror image of master.
interface histogram_sequencer_if;
    logic [7:0] histXAddress;
    logic [7:0] histYAddress;
    logic       histPixelData;
    logic       clearHistogram;
    logic       startHistogram;
    logic       stopHistogram;
    logic       readHistogram;
    logic       histReady;
    logic [7:0] xHistogramOut;
    logic [7:0] yHistogramOut;
    logic       xValid;
    logic       yValid;

    modport master (
        output histXAddress, histYAddress, histPixelData,
        output clearHistogram, startHistogram, stopHistogram, readHistogram,
        input  histReady, xHistogramOut, yHistogramOut, xValid, yValid
    );

    modport slave (
        input  histXAddress, histYAddress, histPixelData,
        input  clearHistogram, startHistogram, stopHistogram, readHistogram,
        output histReady, xHistogramOut, yHistogramOut, xValid, yValid
    );
endinterface

// File: rtl/histogram_sequencer.sv
// histogram_sequencer
// Frame-level controller for the pixel histogram block. A frameStart in IDLE
// clears the histogram, streams one frame of binary pixels into it, stops
// accumulation and reads both projections back while tracking the peak bin of
// each projection.
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-low reset
//   frameStart          request one frame cycle (honoured only in IDLE)
//   pixelValid/pixelIn  binary pixel stream, with its column pixelX / row pixelY
//   hist                histogram connection (addresses, data, commands, readback)
//   busy                high in every state except IDLE
//   frameDone           one-cycle pulse, peak results valid
//   peakX/peakXCount    index and value of the largest x bin (lowest index on ties)
//   peakY/peakYCount    index and value of the largest y bin (lowest index on ties)
//   error               sticky wait timeout flag, cleared by next accepted frameStart
module histogram_sequencer #(
    parameter int IMWIDTH  = 240,
    parameter int IMHEIGHT = 180,
    parameter int TIMEOUT  = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frameStart,
    input  logic                  pixelValid,
    input  logic                  pixelIn,
    input  logic [7:0]            pixelX,
    input  logic [7:0]            pixelY,
    histogram_sequencer_if.master hist,
    output logic                  busy,
    output logic                  frameDone,
    output logic [7:0]            peakX,
    output logic [7:0]            peakY,
    output logic [7:0]            peakXCount,
    output logic [7:0]            peakYCount,
    output logic                  error
);

    typedef enum logic [3:0] {
        IDLE, CLEAR, WAIT_CLEAR, START, STREAM, DRAIN, STOP, READ, WAIT_READ, DONE
    } stateT;

    localparam logic [15:0] LAST_PIXEL = 16'(IMWIDTH * IMHEIGHT - 1);
    localparam logic [7:0]  X_MAX      = 8'(IMWIDTH - 1);
    localparam logic [7:0]  Y_MAX      = 8'(IMHEIGHT - 1);
    // The wait counter starts at 0 on the first wait cycle, so matching
    // TIMEOUT-1 gives up on the TIMEOUT-th cycle spent waiting.
    localparam logic [9:0]  WAIT_LIMIT = 10'(TIMEOUT - 1);

    stateT       state;
    logic [15:0] pixelCount;
    logic [7:0]  xIndex;
    logic [7:0]  yIndex;
    logic [9:0]  waitCount;
    logic        sawLow;

    // Whole controller: state, datapath registers and every output live in one
    // registered block. Command pulses default to 0 and are raised on the
    // transition into the state they belong to, so each lasts one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            pixelCount          <= '0;
            xIndex              <= '0;
            yIndex              <= '0;
            waitCount           <= '0;
            sawLow              <= 1'b0;
            hist.histXAddress   <= '0;
            hist.histYAddress   <= '0;
            hist.histPixelData  <= 1'b0;
            hist.clearHistogram <= 1'b0;
            hist.startHistogram <= 1'b0;
            hist.stopHistogram  <= 1'b0;
            hist.readHistogram  <= 1'b0;
            busy                <= 1'b0;
            frameDone           <= 1'b0;
            peakX               <= '0;
            peakY               <= '0;
            peakXCount          <= '0;
            peakYCount          <= '0;
            error               <= 1'b0;
        end else begin
            hist.clearHistogram <= 1'b0;
            hist.startHistogram <= 1'b0;
            hist.stopHistogram  <= 1'b0;
            hist.readHistogram  <= 1'b0;
            frameDone           <= 1'b0;

            case (state)
                IDLE: begin
                    if (frameStart) begin
                        state               <= CLEAR;
                        hist.clearHistogram <= 1'b1;
                        busy                <= 1'b1;
                        error               <= 1'b0;
                        peakX               <= '0;
                        peakY               <= '0;
                        peakXCount          <= '0;
                        peakYCount          <= '0;
                        pixelCount          <= '0;
                        xIndex              <= '0;
                        yIndex              <= '0;
                        waitCount           <= '0;
                        sawLow              <= 1'b0;
                    end
                end

                CLEAR: begin
                    state     <= WAIT_CLEAR;
                    waitCount <= '0;
                    sawLow    <= 1'b0;
                end

                // The clear is finished once histReady has been seen low and
                // then high again.
                WAIT_CLEAR: begin
                    if (!hist.histReady) begin
                        sawLow <= 1'b1;
                    end
                    if (sawLow && hist.histReady) begin
                        state               <= START;
                        hist.startHistogram <= 1'b1;
                    end else if (waitCount == WAIT_LIMIT) begin
                        state <= IDLE;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        waitCount <= waitCount + 10'd1;
                    end
                end

                START: begin
                    state <= STREAM;
                end

                STREAM: begin
                    hist.histXAddress  <= pixelX;
                    hist.histYAddress  <= pixelY;
                    hist.histPixelData <= pixelIn & pixelValid;
                    if (pixelValid) begin
                        pixelCount <= pixelCount + 16'd1;
                        if (pixelCount == LAST_PIXEL) begin
                            state <= DRAIN;
                        end
                    end
                end

                // The last registered pixel is on the hist outputs during this
                // cycle; zero the data so nothing more gets accumulated.
                DRAIN: begin
                    hist.histPixelData <= 1'b0;
                    hist.stopHistogram <= 1'b1;
                    state              <= STOP;
                end

                STOP: begin
                    hist.readHistogram <= 1'b1;
                    state              <= READ;
                end

                READ: begin
                    xIndex    <= '0;
                    yIndex    <= '0;
                    waitCount <= '0;
                    sawLow    <= 1'b0;
                    state     <= WAIT_READ;
                end

                // Strict greater-than keeps the lowest index on ties; indices
                // saturate so surplus strobes are credited to the last bin.
                WAIT_READ: begin
                    if (hist.xValid) begin
                        if (hist.xHistogramOut > peakXCount) begin
                            peakXCount <= hist.xHistogramOut;
                            peakX      <= xIndex;
                        end
                        if (xIndex != X_MAX) begin
                            xIndex <= xIndex + 8'd1;
                        end
                    end
                    if (hist.yValid) begin
                        if (hist.yHistogramOut > peakYCount) begin
                            peakYCount <= hist.yHistogramOut;
                            peakY      <= yIndex;
                        end
                        if (yIndex != Y_MAX) begin
                            yIndex <= yIndex + 8'd1;
                        end
                    end
                    if (!hist.histReady) begin
                        sawLow <= 1'b1;
                    end
                    if (sawLow && hist.histReady) begin
                        state <= DONE;
                    end else if (waitCount == WAIT_LIMIT) begin
                        state <= IDLE;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        waitCount <= waitCount + 10'd1;
                    end
                end

                DONE: begin
                    frameDone <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_sequencer.sv
// tb_histogram_sequencer
// Drives histogram_sequencer with a 4x3 frame against a behavioural histogram
// model. Expected peaks are queued when a frame is launched and popped when
// the DUT pulses frameDone.
module tb_histogram_sequencer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frameStart = 1'b0;
    logic       pixelValid = 1'b0;
    logic       pixelIn = 1'b0;
    logic [7:0] pixelX = '0;
    logic [7:0] pixelY = '0;
    logic       busy;
    logic       frameDone;
    logic [7:0] peakX;
    logic [7:0] peakY;
    logic [7:0] peakXCount;
    logic [7:0] peakYCount;
    logic       error;

    histogram_sequencer_if histBus();

    histogram_sequencer #(.IMWIDTH(W), .IMHEIGHT(H), .TIMEOUT(1023)) dut (
        .clk        (clk),
        .reset      (reset),
        .frameStart (frameStart),
        .pixelValid (pixelValid),
        .pixelIn    (pixelIn),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .hist       (histBus),
        .busy       (busy),
        .frameDone  (frameDone),
        .peakX      (peakX),
        .peakY      (peakY),
        .peakXCount (peakXCount),
        .peakYCount (peakYCount),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] mask;
        logic        gapped;
        logic [7:0]  ePX;
        logic [7:0]  ePXC;
        logic [7:0]  ePY;
        logic [7:0]  ePYC;
    } frameVecT;

    typedef struct packed {
        logic [7:0] px;
        logic [7:0] pxc;
        logic [7:0] py;
        logic [7:0] pyc;
    } peakT;

    peakT     expQ[$];
    peakT     monExp;
    frameVecT vecs[6];
    int       testsRun = 0;
    int       testsFailed = 0;
    int       doneCount = 0;
    int       cmdPulses = 0;
    bit       ignoreClear = 1'b0;
    bit       extraStrobe = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural histogram: clearing drops histReady for three cycles,
    // accumulation runs between start and stop, readback strobes both
    // projections in parallel and then raises histReady again.
    logic [7:0] xBins [0:3];
    logic [7:0] yBins [0:2];
    logic       accumulating;
    int         clearCount;
    int         readCount;
    logic       reading;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            histBus.histReady     <= 1'b1;
            histBus.xValid        <= 1'b0;
            histBus.yValid        <= 1'b0;
            histBus.xHistogramOut <= '0;
            histBus.yHistogramOut <= '0;
            accumulating          <= 1'b0;
            clearCount            <= 0;
            readCount             <= 0;
            reading               <= 1'b0;
        end else begin
            histBus.xValid <= 1'b0;
            histBus.yValid <= 1'b0;
            if (histBus.clearHistogram) begin
                for (int i = 0; i < W; i++) xBins[i] <= '0;
                for (int i = 0; i < H; i++) yBins[i] <= '0;
                if (!ignoreClear) begin
                    histBus.histReady <= 1'b0;
                    clearCount        <= 3;
                end
            end else if (clearCount > 0) begin
                clearCount <= clearCount - 1;
                if (clearCount == 1) histBus.histReady <= 1'b1;
            end
            if (histBus.startHistogram) accumulating <= 1'b1;
            if (histBus.stopHistogram) accumulating <= 1'b0;
            if (accumulating && histBus.histPixelData) begin
                xBins[histBus.histXAddress[1:0]] <= xBins[histBus.histXAddress[1:0]] + 8'd1;
                yBins[histBus.histYAddress[1:0]] <= yBins[histBus.histYAddress[1:0]] + 8'd1;
            end
            if (histBus.readHistogram) begin
                reading           <= 1'b1;
                readCount         <= 0;
                histBus.histReady <= 1'b0;
            end else if (reading) begin
                if (readCount < W) begin
                    histBus.xValid        <= 1'b1;
                    histBus.xHistogramOut <= xBins[readCount];
                end else if (readCount == W && extraStrobe) begin
                    histBus.xValid        <= 1'b1;
                    histBus.xHistogramOut <= 8'd9;
                end
                if (readCount < H) begin
                    histBus.yValid        <= 1'b1;
                    histBus.yHistogramOut <= yBins[readCount];
                end
                if (readCount == W + 1) begin
                    reading           <= 1'b0;
                    histBus.histReady <= 1'b1;
                end
                readCount <= readCount + 1;
            end
        end
    end

    // Scoreboard: each frameDone consumes one queued expectation.
    always @(negedge clk) begin
        if (reset && frameDone) begin
            doneCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedFrameDone", 1, 0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("peakX", peakX, monExp.px);
                checkOutput("peakXCount", peakXCount, monExp.pxc);
                checkOutput("peakY", peakY, monExp.py);
                checkOutput("peakYCount", peakYCount, monExp.pyc);
                checkOutput("busyAtDone", busy, 0);
            end
        end
    end

    // Commands must never overlap.
    always @(negedge clk) begin
        if (histBus.clearHistogram | histBus.startHistogram | histBus.stopHistogram | histBus.readHistogram) begin
            cmdPulses++;
            checkOutput("oneCommand", $countones({histBus.clearHistogram, histBus.startHistogram,
                                                  histBus.stopHistogram, histBus.readHistogram}), 1);
        end
    end

    // Called at a negedge: drive one stream cycle, then check the registered
    // copy on the hist outputs one cycle later.
    task automatic applyStimulus(input logic v, input logic pin, input logic [7:0] x, input logic [7:0] y);
        pixelValid = v;
        pixelIn    = pin;
        pixelX     = x;
        pixelY     = y;
        @(negedge clk);
        checkOutput("histXAddress", histBus.histXAddress, x);
        checkOutput("histYAddress", histBus.histYAddress, y);
        checkOutput("histPixelData", histBus.histPixelData, pin & v);
    endtask

    // Issue frameStart and return at the negedge of the first STREAM cycle.
    task automatic startFrame();
        int n;
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        checkOutput("clearAfterStart", histBus.clearHistogram, 1);
        checkOutput("busyAfterStart", busy, 1);
        checkOutput("errorClearedByStart", error, 0);
        n = 0;
        while (!histBus.startHistogram && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("startHistogramSeen", histBus.startHistogram, 1);
        @(negedge clk);
    endtask

    task automatic runFrame(input frameVecT v, input bit pokeBusy);
        int i;
        int n;
        int doneBase;
        doneBase = doneCount;
        expQ.push_back('{v.ePX, v.ePXC, v.ePY, v.ePYC});
        startFrame();
        i = 0;
        while (i < NPIX) begin
            if (v.gapped && $urandom_range(0, 2) == 0) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, W - 1)),
                              8'($urandom_range(0, H - 1)));
            end else begin
                applyStimulus(1'b1, v.mask[i], 8'(i % W), 8'(i / W));
                i++;
            end
        end
        pixelValid = 1'b0;
        checkOutput("stopNotAtLastPlus1", histBus.stopHistogram, 0);
        @(negedge clk);
        checkOutput("stopAtLastPlus2", histBus.stopHistogram, 1);
        checkOutput("dataZeroAtStop", histBus.histPixelData, 0);
        @(negedge clk);
        checkOutput("readAtLastPlus3", histBus.readHistogram, 1);
        if (pokeBusy) begin
            @(negedge clk);
            @(negedge clk);
            frameStart = 1'b1;
            @(negedge clk);
            frameStart = 1'b0;
        end
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frameCompletes", busy, 0);
        @(negedge clk);
        if (pokeBusy) begin
            repeat (10) @(negedge clk);
            checkOutput("busyStartIgnored", busy, 0);
        end
        checkOutput("oneFrameDone", doneCount - doneBase, 1);
    endtask

    initial begin
        int n;
        int doneBase;
        int cmdBase;

        vecs[0] = '{12'h064, 1'b0, 8'd2, 8'd2, 8'd1, 8'd2};
        vecs[1] = '{12'h980, 1'b1, 8'd3, 8'd2, 8'd2, 8'd2};
        vecs[2] = '{12'h33B, 1'b0, 8'd0, 8'd3, 8'd0, 8'd3};
        vecs[3] = '{12'h000, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[4] = '{12'hFFF, 1'b1, 8'd0, 8'd3, 8'd0, 8'd4};
        vecs[5] = '{12'h800, 1'b0, 8'd3, 8'd1, 8'd2, 8'd1};

        repeat (3) @(negedge clk);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetFrameDone", frameDone, 0);
        checkOutput("resetError", error, 0);
        checkOutput("resetPeaks", {peakX, peakY, peakXCount, peakYCount}, 0);
        checkOutput("resetHistOut", {histBus.histXAddress, histBus.histYAddress, histBus.histPixelData}, 0);
        checkOutput("resetCommands", {histBus.clearHistogram, histBus.startHistogram,
                                      histBus.stopHistogram, histBus.readHistogram}, 0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("noCmdOnRelease", cmdPulses, 0);

        for (int k = 0; k < 6; k++) begin
            runFrame(vecs[k], 1'b0);
        end

        // Surplus x strobe lands on the saturated last index.
        extraStrobe = 1'b1;
        runFrame('{12'h000, 1'b0, 8'd3, 8'd9, 8'd0, 8'd0}, 1'b0);
        extraStrobe = 1'b0;

        // frameStart during WAIT_READ is ignored.
        runFrame(vecs[0], 1'b1);

        // Timeout: histReady never drops after the clear.
        ignoreClear = 1'b1;
        doneBase = doneCount;
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        checkOutput("timeoutClear", histBus.clearHistogram, 1);
        n = 0;
        while (!error && n < 1100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeoutError", error, 1);
        checkOutput("timeoutWindow", (n >= 1015 && n <= 1030), 1);
        checkOutput("timeoutIdle", busy, 0);
        ignoreClear = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("timeoutNoFrameDone", doneCount - doneBase, 0);
        checkOutput("timeoutErrorSticky", error, 1);
        runFrame(vecs[2], 1'b0);

        // Reset in the middle of STREAM.
        startFrame();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i % W), 8'(i / W));
        end
        cmdBase = cmdPulses;
        reset = 1'b0;
        #1;
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetPeaks", {peakX, peakY, peakXCount, peakYCount}, 0);
        checkOutput("midResetHistOut", {histBus.histXAddress, histBus.histYAddress, histBus.histPixelData}, 0);
        checkOutput("midResetError", {error, frameDone}, 0);
        @(negedge clk);
        reset = 1'b1;
        pixelValid = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("midResetNoCommands", cmdPulses - cmdBase, 0);
        checkOutput("midResetStaysIdle", busy, 0);
        runFrame(vecs[0], 1'b0);

        checkOutput("scoreboardEmpty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected to have ended", $time);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
